// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the digit-serial subtractor.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_NEG  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic MODE_DIFF = 1'b0;
   localparam logic MODE_ABS  = 1'b1;

   // True when the operand width splits into a whole number of digits.
   function automatic bit width_ok(input int unsigned w, input int unsigned d);
      return (d >= 1) && (d <= w) && ((w % d) == 0);
   endfunction

endpackage

// File: rtl/serial_subtractor_digit_subtractor.sv
// DIGIT-bit full subtractor slice: {bout, d} = x - y - bin.
module digit_subtractor #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             bin,
   output logic [DIGIT-1:0] d,
   output logic             bout
);

   logic [DIGIT:0] full_c;

   // The extra top bit wraps to 1 exactly when x < y + bin.
   assign full_c = {1'b0, x} - {1'b0, y} - (DIGIT+1)'(bin);
   assign d      = full_c[DIGIT-1:0];
   assign bout   = full_c[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial A - B - borrow_in with optional absolute-difference pass.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   input  logic             mode,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int unsigned N        = WIDTH / DIGIT;
   localparam int unsigned CNT_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
      $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
   end

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] acc_q;
   logic             brw_q;
   logic             mode_q;
   logic             a_msb_q;
   logic             b_msb_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_out_q;
   logic             overflow_q;
   logic             busy_q;
   logic             done_q;

   logic [DIGIT-1:0] x_c;
   logic [DIGIT-1:0] y_c;
   logic [DIGIT-1:0] d_c;
   logic             bout_c;
   logic [WIDTH-1:0] acc_d;
   logic             last_c;
   logic             accept_c;

   // NEG pass computes 0 - acc, so the minuend digit is forced to zero.
   assign x_c = (state_q == ST_NEG) ? '0 : a_sh_q[DIGIT-1:0];
   assign y_c = b_sh_q[DIGIT-1:0];

   digit_subtractor #(.DIGIT(DIGIT)) u_digit (
      .x    (x_c),
      .y    (y_c),
      .bin  (brw_q),
      .d    (d_c),
      .bout (bout_c)
   );

   // Result digits enter at the top so the LSB digit ends at bit 0.
   assign acc_d    = (acc_q >> DIGIT) | (WIDTH'(d_c) << (WIDTH - DIGIT));
   assign last_c   = (cnt_q == CNT_LAST);
   assign accept_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         a_sh_q       <= '0;
         b_sh_q       <= '0;
         acc_q        <= '0;
         brw_q        <= 1'b0;
         mode_q       <= 1'b0;
         a_msb_q      <= 1'b0;
         b_msb_q      <= 1'b0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         overflow_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (accept_c) begin
                  a_sh_q  <= a;
                  b_sh_q  <= b;
                  brw_q   <= borrow_in;
                  mode_q  <= mode;
                  a_msb_q <= a[WIDTH-1];
                  b_msb_q <= b[WIDTH-1];
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_SUB;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SUB: begin
               acc_q  <= acc_d;
               a_sh_q <= a_sh_q >> DIGIT;
               b_sh_q <= b_sh_q >> DIGIT;
               brw_q  <= bout_c;
               cnt_q  <= cnt_q + CNT_W'(1);
               if (last_c) begin
                  cnt_q <= '0;
                  if ((mode_q == MODE_ABS) && bout_c) begin
                     // Negative result: feed it back as the subtrahend of 0 - x.
                     b_sh_q  <= acc_d;
                     brw_q   <= 1'b0;
                     acc_q   <= '0;
                     state_q <= ST_NEG;
                  end else begin
                     diff_q       <= acc_d;
                     borrow_out_q <= bout_c;
                     overflow_q   <= (mode_q == MODE_DIFF) && (a_msb_q != b_msb_q) &&
                                     (acc_d[WIDTH-1] != a_msb_q);
                     busy_q       <= 1'b0;
                     done_q       <= 1'b1;
                     state_q      <= ST_DONE;
                  end
               end
            end
            ST_NEG: begin
               acc_q  <= acc_d;
               b_sh_q <= b_sh_q >> DIGIT;
               brw_q  <= bout_c;
               cnt_q  <= cnt_q + CNT_W'(1);
               if (last_c) begin
                  // Only reached after a SUB borrow of 1; mode 1 never flags overflow.
                  cnt_q        <= '0;
                  diff_q       <= acc_d;
                  borrow_out_q <= 1'b1;
                  overflow_q   <= 1'b0;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  state_q      <= ST_DONE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;
   assign overflow   = overflow_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and model-checked stimulus for serial_subtractor at WIDTH=16, DIGIT=4.
module tb_serial_subtractor;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DIGIT = 4;
   localparam int unsigned N     = WIDTH / DIGIT;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             mode;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             overflow;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_errors = 0;
   logic both_seen = 1'b0;

   serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .mode       (mode),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (busy && done) both_seen = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                        input logic m);
      a         = av;
      b         = bv;
      borrow_in = bi;
      mode      = m;
      start     = 1'b1;
   endtask

   // Entered at a negedge with lat = edges since accept; returns lat at done.
   task automatic wait_done(input int lat_in, output int lat);
      lat = lat_in;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // One complete operation from IDLE with result and latency checks.
   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic bi, input logic m, input logic [15:0] exp_d,
                         input logic exp_b, input logic exp_o, input int exp_lat);
      int lat;
      @(negedge clk);
      drive(av, bv, bi, m);
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done(0, lat);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_diff"}, 32'(diff), 32'(exp_d));
      chk({tag, "_bout"}, 32'(borrow_out), 32'(exp_b));
      chk({tag, "_ovf"}, 32'(overflow), 32'(exp_o));
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(done), 32'd0);
      chk({tag, "_hold"}, 32'(diff), 32'(exp_d));
   endtask

   initial begin
      int lat;
      logic [16:0] full;
      logic [15:0] rd;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rbi;
      logic        rm;
      logic        ro;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0; mode = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_flags", {28'd0, borrow_out, overflow, busy, done}, 32'd0);
      rst_n = 1'b1;

      run_op("v1",   16'h1234, 16'h0234, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, N);
      run_op("v2",   16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, N);
      run_op("v3",   16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, N);
      run_op("abs1", 16'h0005, 16'h0009, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 2 * N);
      run_op("abs2", 16'h0009, 16'h0005, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0, N);
      run_op("abs3", 16'h8000, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, N);
      run_op("abs4", 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 2 * N);
      run_op("bin",  16'h0100, 16'h00FF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, N);

      // Start while busy is ignored; start then stays high into DONE.
      @(negedge clk);
      drive(16'h0100, 16'h0001, 1'b0, 1'b0);
      @(negedge clk);
      drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      @(negedge clk);
      drive(16'h0010, 16'h0001, 1'b1, 1'b0);
      wait_done(1, lat);
      chk("ign_lat", 32'(lat), 32'(N));
      chk("ign_diff", 32'(diff), 32'h00FF);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      wait_done(0, lat);
      chk("b2b_lat", 32'(lat), 32'(N));
      chk("b2b_diff", 32'(diff), 32'h000E);
      chk("b2b_bout", 32'(borrow_out), 32'd0);

      // Reset during the SUB pass aborts without a done pulse.
      @(negedge clk);
      drive(16'h4321, 16'h0001, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_diff", 32'(diff), 32'd0);
      chk("mid_rst_flags", {28'd0, borrow_out, overflow, busy, done}, 32'd0);
      repeat (N + 2) begin
         @(negedge clk);
         chk("mid_rst_nodone", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      run_op("post_rst", 16'h4321, 16'h0321, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b0, N);

      // Random vectors against a reference model.
      for (int i = 0; i < 16; i++) begin
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rbi = 1'($urandom_range(1));
         rm  = 1'($urandom_range(1));
         full = {1'b0, ra} - {1'b0, rb} - 17'(rbi);
         rd   = full[15:0];
         ro   = !rm && (ra[15] != rb[15]) && (rd[15] != ra[15]);
         if (rm && full[16]) rd = 16'(-rd);
         run_op("rnd", ra, rb, rbi, rm, rd, full[16], ro, (rm && full[16]) ? 2 * N : N);
      end

      chk("busy_done_excl", 32'(both_seen), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor that computes A − B − borrow_in over WIDTH bits, DIGIT bits per clock, with a propagated borrow register. An optional absolute-difference mode re-runs the datapath to negate a negative result. It sits in the arithmetic datapath alongside the bit-level subtractor cells. It is the area-lean, wide-operand successor to the single-bit half subtractor, with a start/done handshake.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  minuend; captured on the accepting edge.
- b  in  WIDTH  subtrahend; captured on the accepting edge.
- borrow_in  in  1  initial borrow; captured on the accepting edge.
- mode  in  1  0 = difference, 1 = absolute difference; captured on the accepting edge.
- diff  out  WIDTH  result; valid while done=1, held until the next accept.
- borrow_out  out  1  final borrow of the A − B − borrow_in pass (1 means A < B + borrow_in).
- overflow  out  1  two's-complement overflow of the subtract pass; forced 0 in mode 1.
- busy  out  1  high in SUB and NEG.
- done  out  1  one-cycle pulse when the result becomes valid.

## Operation
- Let N = WIDTH/DIGIT. The FSM has four states:
  - IDLE: wait for start.
  - SUB: N cycles, processing digit i (LSB first) on the i-th cycle.
  - NEG: N cycles; entered only when mode=1 and the final SUB borrow is 1.
  - DONE: one cycle.
- Transitions:
  - IDLE→SUB on start.
  - SUB→DONE after digit N−1 when mode=0, or when mode=1 and the final borrow is 0.
  - SUB→NEG when mode=1 and the final borrow is 1.
  - NEG→DONE after digit N−1.
  - DONE→SUB on start; otherwise DONE→IDLE.
- SUB digit step: {borrow, d} = a_digit − b_digit − borrow_reg.
  - borrow_reg is loaded with borrow_in on accept.
  - Result digits shift into a WIDTH-bit accumulator.
- NEG pass: computes 0 − diff_acc over N digits with initial borrow 0, giving the two's-complement magnitude.
- borrow_out is the SUB final borrow; the NEG pass never alters it.
- overflow = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]), using the SUB-pass result, mode 0 only.
- Modular arithmetic: results wrap mod 2^WIDTH. Mode 1 with a = 0x8000, b = 0 at WIDTH 16 is not negative, so no NEG pass runs.
- start while busy=1 is ignored; operands are not re-captured.

## Timing
- Reset values: diff=0, borrow_out=0, overflow=0, busy=0, done=0. State is IDLE and all internal registers are 0.
- Accept edge k (start=1 in IDLE or DONE): busy=1 from cycle k+1.
- Latency:
  - Mode 0, or mode 1 with non-negative result: done=1 in the cycle after edge k+N.
  - Mode 1 with negative result: done=1 in the cycle after edge k+2N.
- diff, borrow_out and overflow update on the same edge that raises done. They hold their value through IDLE until the next DONE.
- busy and done are never both 1.
- Back-to-back operation: start high during DONE is accepted. busy rises on the next edge, giving a throughput of one result per N+1 cycles.
- Reset asserted mid-operation clears everything immediately, with no done pulse. Operation resumes on the first rising edge after rst_n deasserts.

## Structure
- Shared arithmetic package holds:
  - the state enum (IDLE, SUB, NEG, DONE);
  - mode constants MODE_DIFF=0 and MODE_ABS=1;
  - a function checking that WIDTH is a multiple of DIGIT (elaboration-time assert).
- One combinational sub-module, digit_subtractor: DIGIT-bit full subtractor slice with ports x, y, bin → d, bout. It is shared by the SUB and NEG passes through an operand mux.
- The top level holds the FSM, digit counter ($clog2(N) bits), operand shift registers, accumulator and borrow register.

## Test plan
- WIDTH=16, DIGIT=4, mode 0: a=0x1234, b=0x0234, borrow_in=0 → diff=0x1000, borrow_out=0, overflow=0. done pulses exactly 4 cycles after the accept edge.
- Mode 0: a=0x0000, b=0x0001 → diff=0xFFFF, borrow_out=1. Then a=0x8000, b=0x0001 → diff=0x7FFF, overflow=1.
- Mode 1: a=0x0005, b=0x0009 → diff=0x0004, borrow_out=1, done at 8 cycles. Then a=0x0009, b=0x0005 → diff=0x0004, borrow_out=0, done at 4 cycles.
- Issue start with a=0xFFFF, b=0x0001 while busy → ignored; the original operation completes unchanged. Start held high through DONE with a=0x0010, b=0x0001, borrow_in=1 → second result diff=0x000E with no idle gap.
- Drive rst_n low in SUB cycle 2 → all outputs 0, no done pulse. A new start after release yields a correct result.
- DIGIT=1 and DIGIT=16 builds: randomised a/b/borrow_in/mode compared against a reference model, with latency N and 2N checked.
